// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Brief    : Unified instruction/data memory slave with a fixed access
//             latency. Accepts one read or write per request, holds it for
//             LATENCY cycles, then returns data alongside a one-cycle
//             mem_ready pulse.
//  Options  : MEM_ALIGN_CHECK_EN - when defined, flags misaligned accesses on
//             err, suppresses misaligned writes and zeroes misaligned reads.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [31:0]       rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam int         c_depth  = 1 << DEPTH_LOG2;
    // Counter is loaded with LATENCY-1 and the FSM spends one extra cycle in
    // WAIT when it reaches zero, so RESP is entered exactly LATENCY edges
    // after the accepting edge.
    localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_cnt;
    logic [3:0]              w_next_cnt;
    logic                    w_req;
    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_misaligned;
    logic                    w_do_write;

    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic                    r_is_write;
    logic [31:0]             r_rdata;
    logic                    r_ready;
    logic                    r_busy;
    logic [31:0]             r_mem [c_depth];

    assign w_req = mem_read | mem_write;

    // Upper address bits only select a wrapped alias of the same word.
`ifdef MEM_ALIGN_CHECK_EN
    logic w_unused_addr;
    assign w_unused_addr = ^addr[ADDR_W-1:DEPTH_LOG2+2];
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};
`endif

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic; a new request may be taken straight out of RESP so
    // that back-to-back accesses run at one per LATENCY+1 cycles.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WAIT;
                    w_next_cnt   = c_lat_m1;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_enter_resp = 1'b1;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WAIT;
                    w_next_cnt   = c_lat_m1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // Latch the request at acceptance; write wins when both lines are high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_idx      <= addr[DEPTH_LOG2+1:2];
            r_wdata    <= wdata;
            r_is_write <= mem_write;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0] r_lo;
    logic       r_err;

    // Byte offset of the latched request, used only for the alignment check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo <= 2'b00;
        end else if (w_accept) begin
            r_lo <= addr[1:0];
        end
    end

    assign w_misaligned = (r_lo != 2'b00);

    // err rides alongside the ready pulse and drops with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_enter_resp) begin
            r_err <= w_misaligned;
        end else if (r_state == ST_RESP) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_misaligned = 1'b0;
    assign err          = 1'b0;
`endif

    // A write commits only on the edge that enters RESP, so a reset during
    // WAIT discards it.
    assign w_do_write = w_enter_resp & r_is_write & ~w_misaligned;

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Response registers: ready pulse, busy flag and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= w_enter_resp;
            r_busy  <= (w_next_state != ST_IDLE);
            if (w_enter_resp) begin
                if (w_misaligned) begin
                    r_rdata <= 32'd0;
                end else if (r_is_write) begin
                    r_rdata <= r_wdata;
                end else begin
                    r_rdata <= r_mem[r_idx];
                end
            end
        end
    end

    assign rdata     = r_rdata;
    assign mem_ready = r_ready;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Brief    : Self-checking bench for mem_responder: table of directed
//             accesses plus hand-written reset and idle sequences.
//             Honours MEM_ALIGN_CHECK_EN for the misalignment vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int c_lat = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    mem_responder #(
        .ADDR_W    (32),
        .DEPTH_LOG2(10),
        .LATENCY   (c_lat)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .rdata    (rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access: request presented before edge N, dropped after it.
    task automatic do_access(input vec_t v);
        int k;
        mem_read  = v.rd;
        mem_write = v.wr;
        addr      = v.a;
        wdata     = v.wd;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check({v.name, " busy_after_accept"}, 32'(busy), 32'd1);
        k = 0;
        while (!mem_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({v.name, " latency"}, 32'(k), 32'(c_lat));
        check({v.name, " err"}, 32'(err), 32'(v.exp_err));
        if (v.chk_rd) check({v.name, " rdata"}, rdata, v.exp_rd);
        @(posedge clk);
        #1;
        check({v.name, " ready_drop"}, {30'd0, mem_ready, busy}, 32'd0);
    endtask

    task automatic add(input string n, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic chk, input logic [31:0] exp_rd,
                       input logic exp_err);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
        v.chk_rd = chk; v.exp_rd = exp_rd; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    initial begin
        int seen;
        logic [31:0] hold;

        add("wr_10",    0, 1, 32'h10,   32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
        add("rd_10",    1, 0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0);
        add("wr_1004",  0, 1, 32'h1004, 32'h12345678, 1, 32'h12345678, 0);
        add("rd_wrap4", 1, 0, 32'h4,    32'h0,        1, 32'h12345678, 0);
        add("both_20",  1, 1, 32'h20,   32'hA5A5A5A5, 1, 32'hA5A5A5A5, 0);
        add("rd_20",    1, 0, 32'h20,   32'h0,        1, 32'hA5A5A5A5, 0);
        add("wr_40",    0, 1, 32'h40,   32'h11110000, 1, 32'h11110000, 0);
        add("raw_10",   0, 1, 32'h10,   32'h0BADCAFE, 1, 32'h0BADCAFE, 0);
        add("rd_10b",   1, 0, 32'h10,   32'h0,        1, 32'h0BADCAFE, 0);

        rst_n = 1'b0; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {rdata[0], mem_ready, busy, err, 28'd0} | {4'd0, rdata[31:4]}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // Idle: nothing may move for 20 cycles.
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready || busy || err || rdata != 32'd0) seen++;
        end
        check("idle_quiet", 32'(seen), 32'd0);

        foreach (vecs[i]) do_access(vecs[i]);

        // Idle after an access: rdata must hold, no spurious ready.
        hold = 32'h0BADCAFE;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready || busy || rdata != hold) seen++;
        end
        check("idle_hold", 32'(seen), 32'd0);

        // Reset while in WAIT aborts the write.
        mem_write = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_reset_state", {30'd0, mem_ready, busy}, 32'd0);
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (mem_ready) seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mem_ready || busy) seen++;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        check("abort_rdata_reset", rdata, 32'd0);

        vecs.delete();
        add("rd_40_prior", 1, 0, 32'h40, 32'h0, 1, 32'h11110000, 0);
`ifdef MEM_ALIGN_CHECK_EN
        add("wr_42_mis",   0, 1, 32'h42, 32'hFFFFFFFF, 0, 32'h0,        1);
        add("rd_40_keep",  1, 0, 32'h40, 32'h0,        1, 32'h11110000, 0);
        add("rd_43_mis",   1, 0, 32'h43, 32'h0,        1, 32'h0,        1);
`else
        add("wr_42",       0, 1, 32'h42, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0);
        add("rd_40_new",   1, 0, 32'h40, 32'h0,        1, 32'hFFFFFFFF, 0);
        add("rd_43",       1, 0, 32'h43, 32'h0,        1, 32'hFFFFFFFF, 0);
`endif
        foreach (vecs[i]) do_access(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
